// File: rtl/flp32_mac_arb_pkg.sv
// ---------------------------------------------------------------------------
// flp32_mac_arb_pkg
// Shared definitions for the FP32 MAC arbiter slice: operand width, the bit
// positions inside the 4-bit response flag vector {sign,zero,nan,inf}, the
// response-flags type and a helper that packs the MAC status bits into it.
// ---------------------------------------------------------------------------
package flp32_mac_arb_pkg;

  localparam int FP_W      = 32;
  localparam int FLAG_W    = 4;
  localparam int FLAG_SIGN = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NAN  = 1;
  localparam int FLAG_INF  = 0;

  typedef logic [FLAG_W-1:0] rsp_flags_t;

  function automatic rsp_flags_t pack_flags(input logic sign, input logic zero,
                                            input logic nan, input logic inf);
    rsp_flags_t f;
    f            = '0;
    f[FLAG_SIGN] = sign;
    f[FLAG_ZERO] = zero;
    f[FLAG_NAN]  = nan;
    f[FLAG_INF]  = inf;
    return f;
  endfunction

endpackage

// File: rtl/flp_rr_arb.sv
// ---------------------------------------------------------------------------
// flp_rr_arb
// Round-robin arbiter. The search for a winner starts one past the last
// granted index and wraps modulo NREQ. The pointer only moves when a grant is
// issued; a grant is always a transfer because req is already qualified by
// the requester valids and the enable.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointer -> NREQ-1)
//   req        qualified request vector
//   grant      one-hot (or zero) grant, combinational
//   grant_id   binary index of the granted requester
// ---------------------------------------------------------------------------
module flp_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id
);

  logic [IW-1:0] ptr;

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + 1 + i) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst)         ptr <= IW'(NREQ - 1);
    else if (|grant) ptr <= grant_id;
  end

endmodule

// File: rtl/flp32_mac_arb.sv
// ---------------------------------------------------------------------------
// flp32_mac_arb
// Shares one 5-stage FP32 MAC among NREQ requesters. One operation is granted
// per cycle (round-robin), its operands are registered onto the MAC inputs,
// and a {valid,id} tag travels alongside the MAC pipeline so the result can be
// steered back to the issuer as a one-hot strobe. Transfer to o_rsp_valid is
// MAC_LAT+2 cycles; responses cannot be back-pressured.
// Optional build macro FLP32_MAC_ARB_CHECK_EN: compare i_mac_valid against the
// exiting tag every cycle and latch o_err on disagreement; responses then also
// require i_mac_valid. Without it o_err is tied low.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_en                      grant enable (low: no new grants, drain only)
//   i_req_valid/o_req_ready   per-requester handshake
//   i_req_a/b/c               packed operands, requester k at [32k+31:32k]
//   o_mac_a/b/c, o_mac_valid  MAC input side
//   i_mac_p, i_mac_sign/zero/nan/inf, i_mac_valid   MAC output side
//   o_rsp_valid/p/flags       registered one-hot response, flags {s,z,n,i}
//   o_busy                    any operation in flight
//   o_err                     sticky tag-mismatch flag
// ---------------------------------------------------------------------------
module flp32_mac_arb
  import flp32_mac_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int MAC_LAT = 5,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [NREQ-1:0]    i_req_valid,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic [NREQ*32-1:0] i_req_a,
  input  logic [NREQ*32-1:0] i_req_b,
  input  logic [NREQ*32-1:0] i_req_c,
  output logic [31:0]        o_mac_a,
  output logic [31:0]        o_mac_b,
  output logic [31:0]        o_mac_c,
  output logic               o_mac_valid,
  input  logic [31:0]        i_mac_p,
  input  logic               i_mac_sign,
  input  logic               i_mac_zero,
  input  logic               i_mac_nan,
  input  logic               i_mac_inf,
  input  logic               i_mac_valid,
  output logic [NREQ-1:0]    o_rsp_valid,
  output logic [31:0]        o_rsp_p,
  output rsp_flags_t         o_rsp_flags,
  output logic               o_busy,
  output logic               o_err
);

  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            xfer;

  // Nothing is offered during reset so ready reads zero while rst is high.
  assign req_q = i_req_valid & {NREQ{i_en & ~rst}};

  flp_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign o_req_ready = grant;
  assign xfer        = |grant;

  // Operand stage: o_mac_valid is a one-cycle strobe, data holds otherwise.
  logic [IW-1:0] mac_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mac_valid <= 1'b0;
      mac_id      <= '0;
      o_mac_a     <= '0;
      o_mac_b     <= '0;
      o_mac_c     <= '0;
    end else begin
      o_mac_valid <= xfer;
      if (xfer) begin
        mac_id  <= grant_id;
        o_mac_a <= i_req_a[FP_W*int'(grant_id) +: FP_W];
        o_mac_b <= i_req_b[FP_W*int'(grant_id) +: FP_W];
        o_mac_c <= i_req_c[FP_W*int'(grant_id) +: FP_W];
      end
    end
  end

  // Tag pipe: stage 0 loads while the MAC samples its inputs, so the last
  // stage is valid in the same cycle the MAC presents that result.
  logic [MAC_LAT-1:0] tag_v;
  logic [IW-1:0]      tag_id [MAC_LAT];

  always_ff @(posedge clk) begin
    if (rst) tag_v <= '0;
    else     tag_v <= {tag_v[MAC_LAT-2:0], o_mac_valid};
  end

  // NOTE: the id payload is never reset; the valid bits alone decide whether
  // a stage means anything, so clearing them is enough.
  always_ff @(posedge clk) begin
    tag_id[0] <= mac_id;
    for (int i = 1; i < MAC_LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  logic          exit_v;
  logic [IW-1:0] exit_id;
  logic          rsp_fire;

  assign exit_v  = tag_v[MAC_LAT-1];
  assign exit_id = tag_id[MAC_LAT-1];

`ifdef FLP32_MAC_ARB_CHECK_EN
  assign rsp_fire = exit_v & i_mac_valid;

  always_ff @(posedge clk) begin
    if (rst)                          o_err <= 1'b0;
    else if (i_mac_valid != exit_v)   o_err <= 1'b1;
  end
`else
  // The MAC's own valid is not consulted; the tag alone steers the result.
  logic unused_mac_valid;
  assign unused_mac_valid = i_mac_valid;
  assign rsp_fire         = exit_v;
  assign o_err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rsp_valid <= '0;
      o_rsp_p     <= '0;
      o_rsp_flags <= '0;
    end else begin
      o_rsp_valid <= '0;
      if (rsp_fire) begin
        o_rsp_valid <= NREQ'(1) << exit_id;
        o_rsp_p     <= i_mac_p;
        o_rsp_flags <= pack_flags(i_mac_sign, i_mac_zero, i_mac_nan, i_mac_inf);
      end
    end
  end

  assign o_busy = o_mac_valid | (|tag_v) | (|o_rsp_valid);

endmodule

// File: tb/tb_flp32_mac_arb.sv
// ---------------------------------------------------------------------------
// tb_flp32_mac_arb
// Directed bench for flp32_mac_arb. A behavioural MAC with MAC_LAT cycles of
// delay returns known products for the reference vectors and a fixed mixing
// function otherwise. Monitors log handshakes and response strobes; each test
// task compares those logs and DUT outputs with hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_flp32_mac_arb;

  localparam int NREQ    = 4;
  localparam int MAC_LAT = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_en;
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ-1:0]    o_req_ready;
  logic [NREQ*32-1:0] i_req_a, i_req_b, i_req_c;
  logic [31:0]        o_mac_a, o_mac_b, o_mac_c;
  logic               o_mac_valid;
  logic [31:0]        i_mac_p;
  logic               i_mac_sign, i_mac_zero, i_mac_nan, i_mac_inf, i_mac_valid;
  logic [NREQ-1:0]    o_rsp_valid;
  logic [31:0]        o_rsp_p;
  logic [3:0]         o_rsp_flags;
  logic               o_busy;
  logic               o_err;
  logic               inject;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  flp32_mac_arb #(.NREQ(NREQ), .MAC_LAT(MAC_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_c     (i_req_c),
    .o_mac_a     (o_mac_a),
    .o_mac_b     (o_mac_b),
    .o_mac_c     (o_mac_c),
    .o_mac_valid (o_mac_valid),
    .i_mac_p     (i_mac_p),
    .i_mac_sign  (i_mac_sign),
    .i_mac_zero  (i_mac_zero),
    .i_mac_nan   (i_mac_nan),
    .i_mac_inf   (i_mac_inf),
    .i_mac_valid (i_mac_valid),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_p     (o_rsp_p),
    .o_rsp_flags (o_rsp_flags),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- behavioural MAC ----------------------------------------------------
  function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    if (a == 32'h401a3237 && b == 32'h3eae76d1 && c == 32'h3ee9c749) return 32'h40242756;
    if (a == 32'hbe1b902b && b == 32'h3fa40b3b && c == 32'hbea63e5b) return 32'hbf116b48;
    return a ^ {b[15:0], b[31:16]} ^ c;
  endfunction

  function automatic logic [3:0] flags_fn(input logic [31:0] p);
    return {p[31], p[30:0] == 31'd0, p[30:23] == 8'hff && p[22:0] != 23'd0,
            p[30:23] == 8'hff && p[22:0] == 23'd0};
  endfunction

  logic [MAC_LAT-1:0] mv_pipe = '0;
  logic [31:0]        mp_pipe [MAC_LAT];

  always @(posedge clk) begin
    mv_pipe    <= {mv_pipe[MAC_LAT-2:0], o_mac_valid};
    mp_pipe[0] <= mac_fn(o_mac_a, o_mac_b, o_mac_c);
    for (int i = 1; i < MAC_LAT; i++) mp_pipe[i] <= mp_pipe[i-1];
  end

  assign i_mac_valid = mv_pipe[MAC_LAT-1] | inject;
  assign i_mac_p     = mp_pipe[MAC_LAT-1];
  assign {i_mac_sign, i_mac_zero, i_mac_nan, i_mac_inf} = flags_fn(i_mac_p);

  // ---- monitors (log only) -------------------------------------------------
  typedef struct { int cyc; int id; logic [31:0] p; logic [3:0] f; } xfer_t;
  typedef struct { int cyc; logic [3:0] v; logic [31:0] p; logic [3:0] f; } rsp_t;
  xfer_t xq[$];
  rsp_t  rq[$];

  always @(negedge clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (i_req_valid[k] && o_req_ready[k]) begin
        logic [31:0] p;
        p = mac_fn(i_req_a[k*32 +: 32], i_req_b[k*32 +: 32], i_req_c[k*32 +: 32]);
        xq.push_back('{cyc, k, p, flags_fn(p)});
      end
    end
    if (|o_rsp_valid) rq.push_back('{cyc, o_rsp_valid, o_rsp_p, o_rsp_flags});
  end

  // ---- stimulus helpers ----------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
    i_req_a[k*32 +: 32] = a;
    i_req_b[k*32 +: 32] = b;
    i_req_c[k*32 +: 32] = c;
  endtask

  task automatic fill_ops(input int seed);
    for (int k = 0; k < NREQ; k++)
      set_ops(k, 32'h3f800000 + 32'(seed * 16 + k), 32'h40000000 ^ 32'(seed << 8),
              32'h00c0ffee + 32'(k << 20));
  endtask

  task automatic do_reset(input int n);
    i_req_valid = '0;
    rst = 1'b1;
    step(n);
    rst = 1'b0;
    xq.delete();
    rq.delete();
  endtask

  // ---- tests ---------------------------------------------------------------
  task automatic test_reset;
    i_en = 1'b1; i_req_valid = '1; rst = 1'b1;
    step(3);
    #1;
    checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", o_req_ready); end
    checks++; if (o_mac_valid !== 1'b0) begin errors++; $display("FAIL rst_mac_valid got %b want 0", o_mac_valid); end
    checks++; if (o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid got %b want 0000", o_rsp_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_busy); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", o_err); end
    checks++; if ({o_mac_a, o_mac_b, o_mac_c} !== 96'd0) begin errors++; $display("FAIL rst_mac_ops got %h want 0", {o_mac_a, o_mac_b, o_mac_c}); end
    checks++; if (o_rsp_p !== 32'd0) begin errors++; $display("FAIL rst_rsp_p got %h want 0", o_rsp_p); end
    checks++; if (o_rsp_flags !== 4'd0) begin errors++; $display("FAIL rst_rsp_flags got %b want 0000", o_rsp_flags); end
    i_req_valid = '0; rst = 1'b0;
    xq.delete(); rq.delete();
    step();
  endtask

  task automatic test_single;
    fill_ops(1);
    set_ops(2, 32'h401a3237, 32'h3eae76d1, 32'h3ee9c749);
    i_req_valid = 4'b0100;
    #1;
    checks++; if (o_req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", o_req_ready); end
    step();
    i_req_valid = '0;
    checks++; if (o_mac_valid !== 1'b1) begin errors++; $display("FAIL single_mac_valid got %b want 1", o_mac_valid); end
    checks++; if ({o_mac_a, o_mac_b, o_mac_c} !== 96'h401a3237_3eae76d1_3ee9c749) begin errors++; $display("FAIL single_mac_ops got %h want 401a3237_3eae76d1_3ee9c749", {o_mac_a, o_mac_b, o_mac_c}); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", o_busy); end
    step();
    checks++; if (o_mac_valid !== 1'b0) begin errors++; $display("FAIL single_mac_strobe got %b want 0", o_mac_valid); end
    checks++; if (o_mac_a !== 32'h401a3237) begin errors++; $display("FAIL single_mac_hold got %h want 401a3237", o_mac_a); end
    for (int t = 0; t < 20 && rq.size() < 1; t++) step();
    checks++; if (rq.size() !== 1 || xq.size() !== 1) begin
      errors++; $display("FAIL single_count got rsp %0d xfer %0d want 1 1", rq.size(), xq.size());
    end else begin
      checks++; if (rq[0].v !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b want 0100", rq[0].v); end
      checks++; if (rq[0].p !== 32'h40242756) begin errors++; $display("FAIL single_rsp_p got %h want 40242756", rq[0].p); end
      checks++; if (rq[0].f !== 4'b0000) begin errors++; $display("FAIL single_rsp_flags got %b want 0000", rq[0].f); end
      checks++; if (rq[0].cyc - xq[0].cyc !== 7) begin errors++; $display("FAIL single_latency got %0d want 7", rq[0].cyc - xq[0].cyc); end
    end
    checks++; if (o_rsp_valid !== 4'b0000 || o_rsp_p !== 32'h40242756) begin errors++; $display("FAIL single_hold got %b %h want 0000 40242756", o_rsp_valid, o_rsp_p); end
  endtask

  task automatic test_alternate;
    do_reset(2);
    fill_ops(2);
    i_req_valid = 4'b1001;
    for (int t = 0; t < 20; t++) begin
      step();
      if (xq.size() >= 4) break;
      fill_ops(3 + t);
    end
    i_req_valid = '0;
    checks++; if (xq.size() !== 4) begin
      errors++; $display("FAIL alt_xfers got %0d want 4", xq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (xq[i].id !== ((i % 2 == 0) ? 0 : 3) || xq[i].cyc !== xq[0].cyc + i) begin
          errors++; $display("FAIL alt_grant%0d got id %0d cyc +%0d want %0d +%0d", i, xq[i].id, xq[i].cyc - xq[0].cyc, (i % 2 == 0) ? 0 : 3, i);
        end
      end
    end
    for (int t = 0; t < 30 && rq.size() < 4; t++) step();
    checks++; if (rq.size() !== 4 || xq.size() !== 4) begin
      errors++; $display("FAIL alt_rsps got %0d want 4", rq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rq[i].v !== (4'b0001 << xq[i].id) || rq[i].p !== xq[i].p || rq[i].f !== xq[i].f || rq[i].cyc !== xq[i].cyc + 7) begin
          errors++; $display("FAIL alt_rsp%0d got %b %h %b cyc %0d want %b %h %b cyc %0d", i, rq[i].v, rq[i].p, rq[i].f, rq[i].cyc, 4'b0001 << xq[i].id, xq[i].p, xq[i].f, xq[i].cyc + 7);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int hits;
    xq.delete(); rq.delete();
    fill_ops(10);
    set_ops(1, 32'hbe1b902b, 32'h3fa40b3b, 32'hbea63e5b);
    i_req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      #1;
      checks++; if (!$onehot(o_req_ready)) begin errors++; $display("FAIL b2b_onehot%0d got %b want one-hot", t, o_req_ready); end
      step();
      fill_ops(11 + t);
      set_ops(1, 32'hbe1b902b, 32'h3fa40b3b, 32'hbea63e5b);
    end
    i_req_valid = '0;
    for (int t = 0; t < 30 && rq.size() < 8; t++) step();
    checks++; if (rq.size() !== 8 || xq.size() !== 8) begin
      errors++; $display("FAIL b2b_count got rsp %0d xfer %0d want 8 8", rq.size(), xq.size());
    end else begin
      hits = 0;
      for (int i = 0; i < 8; i++) begin
        checks++; if (xq[i].id !== i % 4 || rq[i].v !== (4'b0001 << (i % 4)) || rq[i].p !== xq[i].p || rq[i].f !== xq[i].f || rq[i].cyc !== rq[0].cyc + i) begin
          errors++; $display("FAIL b2b_rsp%0d got id %0d %b %h cyc +%0d want id %0d %h +%0d", i, xq[i].id, rq[i].v, rq[i].p, rq[i].cyc - rq[0].cyc, i % 4, xq[i].p, i);
        end
        if (rq[i].v == 4'b0010 && rq[i].p == 32'hbf116b48 && rq[i].f == 4'b1000) hits++;
      end
      checks++; if (hits !== 2) begin errors++; $display("FAIL b2b_req1_result got %0d hits want 2 (bf116b48)", hits); end
    end
  endtask

  task automatic test_enable;
    do_reset(2);
    fill_ops(20);
    i_en = 1'b1;
    i_req_valid = 4'b1111;
    step(2);
    i_en = 1'b0;
    #1;
    checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL en_ready got %b want 0000", o_req_ready); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL en_busy_inflight got %b want 1", o_busy); end
    step(13);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL en_busy_drained got %b want 0", o_busy); end
    checks++; if (xq.size() !== 2 || rq.size() !== 2) begin errors++; $display("FAIL en_drain got xfer %0d rsp %0d want 2 2", xq.size(), rq.size()); end
    i_en = 1'b1;
    #1;
    checks++; if (o_req_ready !== 4'b0100) begin errors++; $display("FAIL en_resume got %b want 0100", o_req_ready); end
    step();
    i_req_valid = '0;
    for (int t = 0; t < 20 && rq.size() < 3; t++) step();
    checks++; if (rq.size() !== 3 || rq[2].v !== 4'b0100) begin errors++; $display("FAIL en_resume_rsp got %0d rsps want 3 ending 0100", rq.size()); end
  endtask

  task automatic test_reset_mid;
    do_reset(2);
    fill_ops(30);
    i_req_valid = 4'b1111;
    step(3);
    i_req_valid = '0;
    step();
    checks++; if (o_busy !== 1'b1 || xq.size() !== 3) begin errors++; $display("FAIL midrst_inflight got busy %b xfer %0d want 1 3", o_busy, xq.size()); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", o_busy); end
    step(12);
    checks++; if (rq.size() !== 0) begin errors++; $display("FAIL midrst_no_rsp got %0d strobes want 0", rq.size()); end
    i_req_valid = 4'b1111;
    #1;
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b want 0001", o_req_ready); end
    step();
    i_req_valid = '0;
  endtask

  task automatic test_spurious;
    step(10);
    do_reset(2);
    step(8);
    inject = 1'b1;
    step();
    inject = 1'b0;
`ifdef FLP32_MAC_ARB_CHECK_EN
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL spur_err got %b want 1", o_err); end
`else
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL spur_err got %b want 0", o_err); end
`endif
    checks++; if (o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL spur_rsp got %b want 0000", o_rsp_valid); end
    step(2);
`ifdef FLP32_MAC_ARB_CHECK_EN
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky got %b want 1", o_err); end
`else
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL spur_err_sticky got %b want 0", o_err); end
`endif
    checks++; if (rq.size() !== 0) begin errors++; $display("FAIL spur_no_rsp got %0d strobes want 0", rq.size()); end
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_req_valid = '0; inject = 1'b0;
    i_req_a = '0; i_req_b = '0; i_req_c = '0;
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flp32_mac_arb.md
FLP32_MAC_ARB -- requirements
Module: flp32_mac_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one flp32_mac_5stg.
REQ-002 SHALL have parameter MAC_LAT, default 5, MAC latency in cycles from i_valid to o_valid.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_en  input  1  grant enable; low blocks new grants, in-flight ops complete.
REQ-006 SHALL have port i_req_valid  input  NREQ  per-requester operation valid.
REQ-007 SHALL have port o_req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have ports i_req_a, i_req_b, i_req_c  input  NREQ*32 each  packed FP32 operands, requester k at bits [32k+31:32k].
REQ-009 SHALL have ports o_mac_a, o_mac_b, o_mac_c  output  32 each, and o_mac_valid  output  1, driving the MAC inputs.
REQ-010 SHALL have ports i_mac_p  input  32, i_mac_sign, i_mac_zero, i_mac_nan, i_mac_inf, i_mac_valid  input  1 each, from the MAC outputs.
REQ-011 SHALL have ports o_rsp_valid  output  NREQ  one-hot result strobe; o_rsp_p  output  32; o_rsp_flags  output  4  {sign,zero,nan,inf}.
REQ-012 SHALL have ports o_busy  output  1  any op in flight; o_err  output  1  sticky tag-mismatch flag.

Function
REQ-013 SHALL grant at most one requester per cycle by round-robin: search starts at last granted index +1, wraps modulo NREQ.
REQ-014 SHALL assert o_req_ready[k] combinationally iff i_en, i_req_valid[k] and k wins arbitration; a transfer occurs when valid and ready are both high at a rising edge.
REQ-015 SHALL update the round-robin pointer only on a transfer; with no transfer the pointer holds.
REQ-016 SHALL register the accepted operands to o_mac_a/b/c and set o_mac_valid high for exactly the cycle after the transfer; o_mac_a/b/c hold their last value otherwise.
REQ-017 SHALL carry {valid, requester id} through a tag shift register of depth MAC_LAT, aligned so the tag exits as i_mac_valid for that operation arrives.
REQ-018 SHALL register responses: on i_mac_valid with a valid tag id k, the next cycle drives o_rsp_valid = one-hot(k), o_rsp_p = i_mac_p, o_rsp_flags = MAC flags.
REQ-019 SHALL give a total latency of MAC_LAT+2 cycles from transfer edge to o_rsp_valid, with sustained throughput of one op per cycle and no back-pressure on responses.
REQ-020 SHALL hold o_rsp_p/o_rsp_flags between strobes; o_rsp_valid is all-zero when no result.
REQ-021 SHALL drive o_busy high while o_mac_valid, any tag stage, or the response register is valid.
REQ-022 SHALL, when i_en falls with requests pending, grant nothing further and drain in-flight ops normally.

Reset
REQ-023 SHALL on rst clear: o_req_ready, o_mac_valid, o_rsp_valid, all tag valids, o_busy, o_err to 0; o_mac_a/b/c, o_rsp_p, o_rsp_flags to 0; round-robin pointer to NREQ-1 so requester 0 wins first.
REQ-024 SHALL on reset mid-operation discard all in-flight tags; MAC results arriving afterwards without a valid tag produce no o_rsp_valid.

Configuration
REQ-025 SHALL compile tag checking under macro FLP32_MAC_ARB_CHECK_EN.
REQ-026 SHALL with FLP32_MAC_ARB_CHECK_EN defined set o_err (sticky until rst) when i_mac_valid differs from the tag-exit valid in any cycle.
REQ-027 SHALL without FLP32_MAC_ARB_CHECK_EN tie o_err to 0 and gate responses only on the tag-exit valid.

Structure
REQ-028 SHALL place the FP32 width constant, the flag-vector bit positions (sign, zero, nan, inf), and the response-flags type in the shared flp package.
REQ-029 SHALL implement arbitration in one sub-module flp_rr_arb (NREQ requests, pointer, one-hot grant); tag pipe and registers stay in flp32_mac_arb.

Verification
REQ-030 SHALL cover: requester 2 issues a=401a3237, b=3eae76d1, c=3ee9c749 -> o_rsp_valid=4'b0100 with o_rsp_p=40242756 exactly 7 cycles after transfer.
REQ-031 SHALL cover: requesters 0 and 3 both valid continuously -> grants alternate 0,3,0,3; each result returns to the issuer in order.
REQ-032 SHALL cover: all 4 valid for 8 cycles, requester 1 issues a=be1b902b, b=3fa40b3b, c=bea63e5b -> 8 back-to-back strobes, requester 1's o_rsp_p=bf116b48.
REQ-033 SHALL cover: i_en low with requests pending -> o_req_ready=0, o_busy falls after drain; i_en high -> grants resume from saved pointer.
REQ-034 SHALL cover: rst asserted with 3 ops in flight -> no o_rsp_valid follows; first grant after reset goes to requester 0.
REQ-035 SHALL cover (FLP32_MAC_ARB_CHECK_EN): inject spurious i_mac_valid with empty tag pipe -> o_err=1 next cycle, no o_rsp_valid.
